// File: rtl/key_event_pkg.sv
// Shared types for the key event controller: event type codes, FSM states
// and the highest valid key index.
package key_event_pkg;

    typedef enum logic [1:0] {
        EV_PRESS   = 2'd0,
        EV_LONG    = 2'd1,
        EV_REPEAT  = 2'd2,
        EV_RELEASE = 2'd3
    } ev_type_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_e;

    localparam logic [2:0] KEY_MAX = 3'd4;
    localparam int         EV_W    = 5;

    function automatic logic [EV_W-1:0] pack_event(input logic [2:0] code, input ev_type_e kind);
        return {code, kind};
    endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through event queue; a push into a full queue is accepted
// when a pop happens in the same cycle.
module key_event_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 5
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] rd_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    // Pointers carry one wrap bit so full and empty are distinguishable.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Converts debounced press/release ticks into queued PRESS, LONG, REPEAT and
// RELEASE events for the menu logic.
module key_event_ctrl
    import key_event_pkg::*;
#(
    parameter int LONG_CYC   = 50_000_000,
    parameter int REP_CYC    = 10_000_000,
    parameter int CNT_W      = 26,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pos_tick,
    input  logic       neg_tick,
    input  logic [2:0] kcode,
    input  logic       sw_clear,
    input  logic       ev_rd,
    input  logic       ovf_clr,
    output logic       ev_valid,
    output logic [2:0] ev_code,
    output logic [1:0] ev_type,
    output logic       overflow,
    output logic       busy
);

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REP_CYC - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         cur_key_q, cur_key_d;
    logic               overflow_q, overflow_d;
    logic               push, pop, drop, release_ev;
    logic [2:0]         push_code;
    ev_type_e           push_type;
    logic [EV_W-1:0]    fifo_rd;
    logic               fifo_full, fifo_empty;

    assign release_ev = neg_tick || sw_clear;

    // Release takes priority over a counter terminal so only RELEASE is queued.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cur_key_d = cur_key_q;
        push      = 1'b0;
        push_code = cur_key_q;
        push_type = EV_PRESS;
        case (state_q)
            ST_IDLE: begin
                if (pos_tick && (kcode <= KEY_MAX)) begin
                    cur_key_d = kcode;
                    push      = 1'b1;
                    push_code = kcode;
                    cnt_d     = '0;
                    state_d   = ST_HELD;
                end
            end
            ST_HELD: begin
                if (release_ev) begin
                    push      = 1'b1;
                    push_type = EV_RELEASE;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == LONG_LAST) begin
                    push      = 1'b1;
                    push_type = EV_LONG;
                    cnt_d     = '0;
                    state_d   = ST_REPEAT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_REPEAT: begin
                if (release_ev) begin
                    push      = 1'b1;
                    push_type = EV_RELEASE;
                    cnt_d     = '0;
                    state_d   = ST_IDLE;
                end else if (cnt_q == REP_LAST) begin
                    push      = 1'b1;
                    push_type = EV_REPEAT;
                    cnt_d     = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign pop  = ev_rd && !fifo_empty;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (ovf_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cur_key_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cur_key_q  <= cur_key_d;
            overflow_q <= overflow_d;
        end
    end

    key_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EV_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (pack_event(push_code, push_type)),
        .pop       (pop),
        .rd_data   (fifo_rd),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign ev_valid = !fifo_empty;
    assign ev_code  = fifo_rd[4:2];
    assign ev_type  = fifo_rd[1:0];
    assign overflow = overflow_q;
    assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_key_event_ctrl.sv
// Bench for key_event_ctrl: directed scenarios plus random traffic, compared
// cycle by cycle with a hold-age event model and a queue-based FIFO model.
module tb_key_event_ctrl;
    import key_event_pkg::*;

    localparam int LONG = 100;
    localparam int REP  = 20;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pos_tick = 1'b0, neg_tick = 1'b0, sw_clear = 1'b0;
    logic [2:0] kcode = 3'd0;
    logic       ev_rd = 1'b0, ovf_clr = 1'b0;
    logic       ev_valid, overflow, busy;
    logic [2:0] ev_code;
    logic [1:0] ev_type;

    int errors = 0;
    int checks = 0;

    // Reference model state: hold tracked by press cycle, queue of events.
    logic [4:0] m_q[$];
    logic [4:0] obs_log[$];
    logic [4:0] exp_log[$];
    bit         m_held = 0;
    bit         m_ovf = 0;
    logic [2:0] m_key = 0;
    int         m_press_cyc = 0;
    int         cyc = 0;

    key_event_ctrl #(
        .LONG_CYC   (LONG),
        .REP_CYC    (REP),
        .CNT_W      (8),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .pos_tick (pos_tick),
        .neg_tick (neg_tick),
        .kcode    (kcode),
        .sw_clear (sw_clear),
        .ev_rd    (ev_rd),
        .ovf_clr  (ovf_clr),
        .ev_valid (ev_valid),
        .ev_code  (ev_code),
        .ev_type  (ev_type),
        .overflow (overflow),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        errors++;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] ev(input logic [2:0] code, input ev_type_e kind);
        return {code, kind};
    endfunction

    task automatic model_push(input logic [4:0] e, input bit popped);
        if (m_q.size() == DEPTH && !popped) begin
            m_ovf = 1;
        end else begin
            m_q.push_back(e);
        end
    endtask

    // One clock: drive inputs on the falling edge, advance the model, check after the rising edge.
    task automatic step(input bit p, input bit n, input logic [2:0] k, input bit s, input bit r, input bit c);
        int  age;
        bit  popped;
        bit  dropped;
        @(negedge clk);
        pos_tick = p; neg_tick = n; kcode = k; sw_clear = s; ev_rd = r; ovf_clr = c;
        if (r && ev_valid) obs_log.push_back({ev_code, ev_type});
        popped  = r && (m_q.size() > 0);
        if (popped) void'(m_q.pop_front());
        dropped = 0;
        if (m_held) begin
            age = cyc - m_press_cyc;
            if (n || s) begin
                m_held = 0;
                if (m_q.size() == DEPTH) dropped = 1;
                model_push(ev(m_key, EV_RELEASE), 1'b0);
            end else if (age == LONG) begin
                if (m_q.size() == DEPTH) dropped = 1;
                model_push(ev(m_key, EV_LONG), 1'b0);
            end else if (age > LONG && (age - LONG) % REP == 0) begin
                if (m_q.size() == DEPTH) dropped = 1;
                model_push(ev(m_key, EV_REPEAT), 1'b0);
            end
        end else if (p && k <= 3'd4) begin
            m_held = 1;
            m_key = k;
            m_press_cyc = cyc;
            if (m_q.size() == DEPTH) dropped = 1;
            model_push(ev(k, EV_PRESS), 1'b0);
        end
        if (!dropped && c) m_ovf = 0;
        @(posedge clk);
        #1;
        cyc++;
        check_output("ev_valid", ev_valid, m_q.size() > 0);
        check_output("busy", busy, m_held);
        check_output("overflow", overflow, m_ovf);
        if (m_q.size() > 0) begin
            check_output("ev_code", ev_code, m_q[0][4:2]);
            check_output("ev_type", ev_type, m_q[0][1:0]);
        end
    endtask

    task automatic idle(input int n, input bit r);
        repeat (n) step(0, 0, 3'd0, 0, r, 0);
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && m_q.size() > 0; i++) step(0, 0, 3'd0, 0, 1, 0);
    endtask

    task automatic compare_log(input string tag);
        check_output({tag, "_count"}, obs_log.size(), exp_log.size());
        for (int i = 0; i < exp_log.size() && i < obs_log.size(); i++)
            check_output($sformatf("%s_ev%0d", tag, i), obs_log[i], exp_log[i]);
        obs_log.delete();
        exp_log.delete();
    endtask

    initial begin
        $display("[TB] start");
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_valid", ev_valid, 0);
        check_output("rst_code", ev_code, 0);
        check_output("rst_type", ev_type, 0);
        check_output("rst_ovf", overflow, 0);
        check_output("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b0;

        // Short press on key 2
        obs_log.delete();
        step(1, 0, 3'd2, 0, 0, 0);
        idle(29, 0);
        step(0, 1, 3'd0, 0, 0, 0);
        drain();
        exp_log = '{ev(2, EV_PRESS), ev(2, EV_RELEASE)};
        compare_log("short");

        // Long hold on key 4 with a draining consumer
        step(1, 0, 3'd4, 0, 1, 0);
        idle(149, 1);
        step(0, 1, 3'd0, 0, 1, 0);
        drain();
        exp_log = '{ev(4, EV_PRESS), ev(4, EV_LONG), ev(4, EV_REPEAT), ev(4, EV_REPEAT), ev(4, EV_RELEASE)};
        compare_log("long");

        // Release coincides with the LONG terminal
        step(1, 0, 3'd0, 0, 0, 0);
        idle(99, 0);
        step(0, 1, 3'd0, 0, 0, 0);
        drain();
        exp_log = '{ev(0, EV_PRESS), ev(0, EV_RELEASE)};
        compare_log("collide");

        // Overflow, drop beating clear, clear, and push+pop while full
        step(1, 0, 3'd1, 0, 0, 0);
        idle(199, 0);
        step(0, 0, 3'd0, 0, 0, 1);
        check_output("ovf_drop_wins", overflow, 1);
        idle(4, 0);
        step(0, 0, 3'd0, 0, 0, 1);
        check_output("ovf_cleared", overflow, 0);
        idle(14, 0);
        step(0, 0, 3'd0, 0, 1, 0);
        check_output("full_pushpop_ovf", overflow, 0);
        check_output("full_pushpop_valid", ev_valid, 1);
        step(0, 1, 3'd0, 0, 1, 0);
        drain();
        exp_log = '{ev(1, EV_PRESS), ev(1, EV_LONG), ev(1, EV_REPEAT), ev(1, EV_REPEAT), ev(1, EV_REPEAT), ev(1, EV_RELEASE)};
        compare_log("ovf");

        // Invalid key code and second key during a hold
        step(1, 0, 3'd6, 0, 0, 0);
        check_output("badkey_valid", ev_valid, 0);
        check_output("badkey_busy", busy, 0);
        step(1, 0, 3'd3, 0, 0, 0);
        idle(9, 0);
        step(1, 0, 3'd1, 0, 0, 0);
        idle(9, 0);
        step(0, 1, 3'd0, 0, 0, 0);
        drain();
        exp_log = '{ev(3, EV_PRESS), ev(3, EV_RELEASE)};
        compare_log("second_key");

        // Release via all-switches-clear
        step(1, 0, 3'd0, 0, 0, 0);
        idle(5, 0);
        step(0, 0, 3'd0, 1, 0, 0);
        step(0, 0, 3'd0, 0, 0, 0);
        drain();
        exp_log = '{ev(0, EV_PRESS), ev(0, EV_RELEASE)};
        compare_log("swclear");

        // Asynchronous reset mid-hold with PRESS and LONG queued
        step(1, 0, 3'd2, 0, 0, 0);
        idle(104, 0);
        check_output("pre_rst_valid", ev_valid, 1);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_output("async_rst_valid", ev_valid, 0);
        check_output("async_rst_busy", busy, 0);
        m_q.delete();
        m_held = 0;
        m_ovf = 0;
        @(negedge clk);
        reset = 1'b0;
        idle(30, 0);
        check_output("post_rst_no_release", ev_valid, 0);

        // Random traffic
        for (int i = 0; i < 2500; i++) begin
            step(($urandom % 30) == 0, ($urandom % 80) == 0, 3'($urandom % 8),
                 ($urandom % 150) == 0, ($urandom % 2) == 0, ($urandom % 20) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_event_ctrl.md
# key_event_ctrl

Turns the single-cycle debounced press/release ticks and key code from the `buttons` debouncer into a queue of typed key events: press, long-press, auto-repeat and release. Sits directly downstream of `buttons` and upstream of the menu/control logic, which drains events through a first-word-fall-through read port. Time bases are cycle counts at the 50 MHz system clock.

## Interface
- `LONG_CYC`, 50_000_000: hold cycles from press to the LONG event (1 s).
- `REP_CYC`, 10_000_000: cycles between REPEAT events after LONG (200 ms).
- `CNT_W`, 26: hold-counter width; must satisfy 2^CNT_W > max(LONG_CYC, REP_CYC).
- `FIFO_DEPTH`, 4: event queue depth, power of two.
- `clk` in 1: system clock, 50 MHz.
- `reset` in 1: asynchronous, active-high; clears FSM, counter, FIFO and flags.
- `pos_tick` in 1: one-cycle debounced press pulse from `buttons`.
- `neg_tick` in 1: one-cycle debounced release pulse from `buttons`.
- `kcode` in 3: key index 0–4, valid in the `pos_tick` cycle.
- `sw_clear` in 1: high when all debounced switches are released.
- `ev_rd` in 1: consumer pop strobe; honoured only while `ev_valid`.
- `ovf_clr` in 1: clears `overflow`.
- `ev_valid` out 1: FIFO not empty.
- `ev_code` out 3: key index of head event.
- `ev_type` out 2: head event type: 0 PRESS, 1 LONG, 2 REPEAT, 3 RELEASE.
- `overflow` out 1: sticky; an event was dropped on a full FIFO.
- `busy` out 1: a key is being held (FSM not IDLE).

## Operation
- FSM states: IDLE, HELD, REPEAT. Hold counter `cnt` and latched key `cur_key`.
- IDLE: on `pos_tick` with `kcode` ≤ 4, latch `cur_key`, push PRESS, clear `cnt`, go to HELD. `pos_tick` with `kcode` ≥ 5 is ignored. `neg_tick` is ignored.
- HELD: `cnt` increments. A release is `neg_tick` or `sw_clear`. On release, push RELEASE and go to IDLE. When `cnt == LONG_CYC-1`, push LONG, clear `cnt` and go to REPEAT.
- REPEAT: `cnt` increments. When `cnt == REP_CYC-1`, push REPEAT and clear `cnt`. On release, push RELEASE and go to IDLE.
- Release and a counter terminal in the same cycle: release wins, and only RELEASE is pushed.
- `pos_tick` while in HELD or REPEAT (second key) is ignored, and `cur_key` is unchanged.
- All events carry `cur_key`; PRESS carries the `kcode` sampled that cycle.
- FIFO push while full: the event is dropped and `overflow` is set. Push and pop in the same cycle while full: both occur and nothing is dropped.
- `ev_rd` while empty has no effect.
- `ovf_clr` clears `overflow` unless a drop occurs in the same cycle; the drop wins.

## Timing
- Reset values: `ev_valid`=0, `ev_code`=0, `ev_type`=0, `overflow`=0, `busy`=0; state IDLE, `cnt`=0, FIFO empty.
- Event latency: a push decided in cycle N makes `ev_valid`/`ev_code`/`ev_type` reflect it in cycle N+1 (empty FIFO case).
- LONG is pushed at the cycle where `cnt` = LONG_CYC-1. The first REPEAT follows REP_CYC cycles after LONG, then every REP_CYC cycles.
- `busy` rises the cycle after the PRESS `pos_tick` and falls the cycle after the release.
- Pop: `ev_rd` high in cycle N with `ev_valid` means the next entry, or `ev_valid`=0, appears in N+1.
- Reset mid-hold or with a non-empty FIFO: contents are discarded immediately (asynchronous), and no RELEASE is emitted.

## Structure
- `key_event_pkg`:
  - event type constants `EV_PRESS`, `EV_LONG`, `EV_REPEAT`, `EV_RELEASE`;
  - FSM state encoding;
  - `KEY_MAX` = 4.
- Sub-module `key_event_fifo`: synchronous FWFT FIFO, 5-bit entries {code, type}, DEPTH parameter, `full`/`empty`, same-cycle push and pop when full.
- Top level holds the FSM, the counter and the overflow flag.

## Test plan
Benches run with LONG_CYC=100 and REP_CYC=20.
- Press then release: `pos_tick` with `kcode`=2, `neg_tick` 30 cycles later → FIFO gives {2,PRESS}, {2,RELEASE}; no LONG.
- Long hold: `kcode`=4, release after 150 cycles → {4,PRESS}, {4,LONG} at cycle 100, REPEAT at 120 and 140, then {4,RELEASE}; `busy` high throughout the hold.
- Collision: `neg_tick` on the cycle `cnt`=99 → only PRESS and RELEASE are queued; no LONG.
- Overflow: no reads, hold for 200 cycles → first 4 events kept (PRESS, LONG, REPEAT, REPEAT), `overflow`=1 and stays 1; pulsing `ovf_clr` clears it. With the FIFO full, `ev_rd` in the same cycle as a REPEAT push → no drop.
- Filtering: `pos_tick` with `kcode`=6 → no event. A second `pos_tick` with `kcode`=1 during a hold of key 3 → events keep code 3.
- Reset mid-hold after LONG with 2 entries queued → `ev_valid`=0 and `busy`=0 immediately; no RELEASE is emitted afterwards.
